gate_checker: RTL and testbench

- Sequential stimulus driver and response monitor for a 3-input combinational gate network whose output is out = in3 | (in1 & in2).
- On start, steps through all 8 input vectors and holds each one for a programmable settle time.
- Samples the network output for each vector and compares it against a parameterised truth table.
- Reports pass/fail, a mismatch count and a per-vector fail mask; acts as the driving and observing end of the gate network's ports.

---
 rtl/gate_checker_if.sv | 36 +++
 rtl/gate_checker.sv | 131 +++++++++++++
 tb/tb_gate_checker.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gate_checker_if.sv
// Bus between gate_checker and the gate network under check plus its controller.
// Macro GATE_CHECKER_FIRST_FAIL_EN adds the first_fail/first_fail_valid signals.
interface gate_checker_if;
    logic       start;
    logic       abort;
    logic       drv_in1;
    logic       drv_in2;
    logic       drv_in3;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_mask;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    logic [2:0] first_fail;
    logic       first_fail_valid;
`endif

    // master is the checker itself; slave is the controller/network side
    modport master (
        input  start, abort, dut_out,
        output drv_in1, drv_in2, drv_in3, busy, done, pass, err_count, fail_mask
`ifdef GATE_CHECKER_FIRST_FAIL_EN
        , output first_fail, first_fail_valid
`endif
    );

    modport slave (
        output start, abort, dut_out,
        input  drv_in1, drv_in2, drv_in3, busy, done, pass, err_count, fail_mask
`ifdef GATE_CHECKER_FIRST_FAIL_EN
        , input first_fail, first_fail_valid
`endif
    );
endinterface

// File: rtl/gate_checker.sv
// Steps a 3-input gate network through all 8 vectors and compares its output to TRUTH_TABLE.
// Optional macro GATE_CHECKER_FIRST_FAIL_EN reports the lowest failing vector index.
module gate_checker #(
    parameter int         SETTLE_CYCLES = 1,
    parameter logic [7:0] TRUTH_TABLE   = 8'hF8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    gate_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [2:0] r_vec;
    logic [2:0] w_vecNext;
    logic [3:0] r_settleCnt;
    logic [2:0] r_drv;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_errCount;
    logic [3:0] w_errNext;
    logic [7:0] r_failMask;
    logic       w_mismatch;
    logic       w_nextActive;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    logic [2:0] r_firstFail;
    logic       r_firstFailValid;
`endif

    always_comb begin
        w_nextState = r_state;
        w_vecNext   = r_vec;
        case (r_state)
            IDLE: begin
                w_vecNext = 3'd0;
                if (bus.start && !bus.abort) w_nextState = SETTLE;
            end
            SETTLE: begin
                if (bus.abort)                                   w_nextState = IDLE;
                else if (r_settleCnt == 4'(SETTLE_CYCLES - 1))   w_nextState = SAMPLE;
            end
            SAMPLE: begin
                if (bus.abort) begin
                    w_nextState = IDLE;
                end else if (r_vec == 3'd7) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = SETTLE;
                    w_vecNext   = r_vec + 3'd1;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // An aborted SAMPLE cycle records nothing; the run is discarded from that point on
    assign w_mismatch   = (r_state == SAMPLE) && !bus.abort && (bus.dut_out != TRUTH_TABLE[r_vec]);
    assign w_errNext    = r_errCount + {3'd0, w_mismatch};
    assign w_nextActive = (w_nextState == SETTLE) || (w_nextState == SAMPLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_vec       <= 3'd0;
            r_settleCnt <= 4'd0;
            r_drv       <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_errCount  <= 4'd0;
            r_failMask  <= 8'd0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
            r_firstFail      <= 3'd0;
            r_firstFailValid <= 1'b0;
`endif
        end else begin
            r_state <= w_nextState;
            r_vec   <= w_vecNext;
            r_done  <= (w_nextState == DONE);
            r_drv   <= w_nextActive ? w_vecNext : 3'd0;
            // busy rises one cycle after the start edge and drops as DONE is entered
            r_busy  <= w_nextActive && ((r_state == SETTLE) || (r_state == SAMPLE));
            case (r_state)
                IDLE: begin
                    if (w_nextState == SETTLE) begin
                        r_settleCnt <= 4'd0;
                        r_errCount  <= 4'd0;
                        r_failMask  <= 8'd0;
                        r_pass      <= 1'b0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
                        r_firstFail      <= 3'd0;
                        r_firstFailValid <= 1'b0;
`endif
                    end
                end
                SETTLE: r_settleCnt <= r_settleCnt + 4'd1;
                SAMPLE: begin
                    if (w_mismatch) begin
                        r_failMask[r_vec] <= 1'b1;
                        r_errCount        <= w_errNext;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
                        if (!r_firstFailValid) begin
                            r_firstFail      <= r_vec;
                            r_firstFailValid <= 1'b1;
                        end
`endif
                    end
                    if (w_nextState == SETTLE) r_settleCnt <= 4'd0;
                    if (w_nextState == DONE)   r_pass      <= (w_errNext == 4'd0);
                end
                default: ;
            endcase
        end
    end

    assign bus.drv_in1   = r_drv[0];
    assign bus.drv_in2   = r_drv[1];
    assign bus.drv_in3   = r_drv[2];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_errCount;
    assign bus.fail_mask = r_failMask;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    assign bus.first_fail       = r_firstFail;
    assign bus.first_fail_valid = r_firstFailValid;
`endif
endmodule

// File: tb/tb_gate_checker.sv
// Randomized bench for gate_checker: two instances (settle 1 and 3) run in lockstep against a
// vector-table reference model. Checks first_fail outputs when GATE_CHECKER_FIRST_FAIL_EN is set.
module tb_gate_checker;
    localparam logic [7:0] TT   = 8'hF8;
    localparam int         LAST = 33;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] respTable = 8'h00;
    int         total = 0;
    int         bad = 0;

    gate_checker_if busA ();
    gate_checker_if busB ();

    gate_checker #(.SETTLE_CYCLES(1), .TRUTH_TABLE(TT)) dutA (.i_clk(clk), .i_rst(rst), .bus(busA));
    gate_checker #(.SETTLE_CYCLES(3), .TRUTH_TABLE(TT)) dutB (.i_clk(clk), .i_rst(rst), .bus(busB));

    always #5 clk = ~clk;

    // The gate network stand-in answers each vector from respTable
    always_comb begin
        busA.dut_out = respTable[{busA.drv_in3, busA.drv_in2, busA.drv_in1}];
        busB.dut_out = respTable[{busB.drv_in3, busB.drv_in2, busB.drv_in1}];
    end

    logic start = 1'b0;
    logic abort = 1'b0;
    assign busA.start = start;
    assign busA.abort = abort;
    assign busB.start = start;
    assign busB.abort = abort;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gateTable();
        logic [7:0] t;
        for (int v = 0; v < 8; v++) t[v] = ((v >> 2) & 1) | ((v & 1) & ((v >> 1) & 1));
        return t;
    endfunction

    // Per-cycle expectation: vector index is k/period while the run is alive
    task automatic checkCycle(input string nm, input int s, input int k, input int cut,
                              input logic [2:0] drv, input logic busy, input logic done);
        int p   = s + 1;
        int len = 8 * p;
        bit running = (k < len) && (cut < 0 || k < cut);
        checkOutput({nm, " drv"},  drv,  running ? (k / p) : 0);
        checkOutput({nm, " busy"}, busy, running && (k >= 1));
        checkOutput({nm, " done"}, done, (cut < 0 || cut > len) && (k == len));
    endtask

    task automatic checkResults(input string nm, input int s, input int cut, input bit isRst,
                                input logic [7:0] resp, input logic [7:0] mask, input logic [3:0] err,
                                input logic pass, input logic [2:0] ff, input logic ffv);
        logic [7:0] expMask = 8'h00;
        int         expErr = 0;
        int         expFf = 0;
        for (int v = 0; v < 8; v++)
            if (!isRst && (cut < 0 || (v + 1) * (s + 1) < cut) && (resp[v] != TT[v])) expMask[v] = 1'b1;
        for (int v = 7; v >= 0; v--)
            if (expMask[v]) begin
                expErr++;
                expFf = v;
            end
        checkOutput({nm, " fail_mask"}, mask, expMask);
        checkOutput({nm, " err_count"}, err, expErr);
        checkOutput({nm, " pass"}, pass, (cut < 0) && (expErr == 0));
`ifdef GATE_CHECKER_FIRST_FAIL_EN
        checkOutput({nm, " first_fail_valid"}, ffv, expMask != 8'h00);
        checkOutput({nm, " first_fail"}, ff, expFf);
`else
        if (ff != 3'd0 || ffv != 1'b0) checkOutput({nm, " first_fail tie"}, {ffv, ff}, 0);
`endif
    endtask

    task automatic checkBoth(input int cut, input bit isRst, input logic [7:0] resp);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
        checkResults("s1", 1, cut, isRst, resp, busA.fail_mask, busA.err_count, busA.pass,
                     busA.first_fail, busA.first_fail_valid);
        checkResults("s3", 3, cut, isRst, resp, busB.fail_mask, busB.err_count, busB.pass,
                     busB.first_fail, busB.first_fail_valid);
`else
        checkResults("s1", 1, cut, isRst, resp, busA.fail_mask, busA.err_count, busA.pass, 3'd0, 1'b0);
        checkResults("s3", 3, cut, isRst, resp, busB.fail_mask, busB.err_count, busB.pass, 3'd0, 1'b0);
`endif
    endtask

    // One run: start edge is k=0; extra start, abort or reset land on the edge numbered by the argument
    task automatic applyStimulus(input logic [7:0] resp, input int startAgainAt, input int abortAt,
                                 input int rstAt);
        int cut = (abortAt >= 0) ? abortAt : rstAt;
        respTable = resp;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= LAST; k++) begin
            checkCycle("s1", 1, k, cut, {busA.drv_in3, busA.drv_in2, busA.drv_in1}, busA.busy, busA.done);
            checkCycle("s3", 3, k, cut, {busB.drv_in3, busB.drv_in2, busB.drv_in1}, busB.busy, busB.done);
            if (k == LAST) checkBoth(cut, rstAt >= 0, resp);
            start = (k + 1 == startAgainAt);
            abort = (k + 1 == abortAt);
            rst   = (k + 1 == rstAt);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        logic [7:0] good;
        logic [7:0] resp;
        good = gateTable();
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset s1 outputs", {busA.drv_in3, busA.drv_in2, busA.drv_in1, busA.busy, busA.done}, 0);
        checkOutput("reset s3 outputs", {busB.drv_in3, busB.drv_in2, busB.drv_in1, busB.busy, busB.done}, 0);
        checkBoth(0, 1'b1, 8'h00);

        applyStimulus(good,  -1, -1, -1);
        applyStimulus(8'h00, -1, -1, -1);
        applyStimulus(8'hFF, -1, -1, -1);
        applyStimulus(good,   5, -1, -1);
        applyStimulus(8'h00, -1,  6, -1);
        applyStimulus(good,  -1, -1, -1);

        for (int i = 0; i < 6; i++) begin
            resp = 8'($urandom_range(0, 255));
            applyStimulus(resp, ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 15)) : -1, -1, -1);
        end

        // start together with abort in IDLE is ignored and results are held
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("idle s1 busy", busA.busy, 0);
            checkOutput("idle s3 drv", {busB.drv_in3, busB.drv_in2, busB.drv_in1}, 0);
            checkOutput("idle s1 done", busA.done, 0);
            @(negedge clk);
        end
        checkBoth(-1, 1'b0, resp);

        applyStimulus(8'h00, -1, -1, 10);
        applyStimulus(8'hFF, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
